// File: rtl/ifetch_queue.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small FIFO toward decode.
// Optional `IFQ_STALL_CNT_EN adds a saturating decode-starvation counter (stall_cnt).
module ifetch_queue #(
  parameter int unsigned QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifq_valid,
  output logic [31:0] ifq_instr,
  output logic [31:0] ifq_pc,
  input  logic        ifq_ready
`ifdef IFQ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t          state, state_n;
  logic [31:0]     fetch_pc, fetch_pc_n;
  logic [31:0]     req_pc, req_pc_n;
  logic [PW-1:0]   rptr, rptr_n, wptr, wptr_n;
  logic [CW-1:0]   count, count_n;
  logic            imem_req_n, ifq_valid_n;
  entry_t          head, head_n;
  entry_t          mem [QDEPTH];
  entry_t          push_entry;
  logic            grant, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign imem_addr  = fetch_pc;
  assign ifq_instr  = head.instr;
  assign ifq_pc     = head.pc;
  assign push_entry = '{instr: imem_rdata, pc: req_pc};

  // Redirect outranks everything; pop is only meaningful when the head is valid.
  assign grant = imem_req && imem_gnt;
  assign push  = (state == WAIT) && imem_rvalid && !redirect;
  assign pop   = ifq_valid && ifq_ready && !redirect;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_pc_n   = req_pc;
    rptr_n     = rptr;
    wptr_n     = wptr;
    count_n    = count;
    head_n     = head;

    if (redirect) begin
      fetch_pc_n = redirect_pc;
      rptr_n     = '0;
      wptr_n     = '0;
      count_n    = '0;
      // An in-flight request must be drained before fetching again.
      case (state)
        FETCH:   state_n = grant ? DRAIN : FETCH;
        WAIT:    state_n = imem_rvalid ? FETCH : DRAIN;
        DRAIN:   state_n = imem_rvalid ? FETCH : DRAIN;
        default: state_n = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (grant) begin
            fetch_pc_n = fetch_pc + 32'd1;
            req_pc_n   = fetch_pc;
            state_n    = WAIT;
          end
        end
        WAIT:    if (imem_rvalid) state_n = FETCH;
        DRAIN:   if (imem_rvalid) state_n = FETCH;
        default: state_n = FETCH;
      endcase
      if (push) wptr_n = ptr_inc(wptr);
      if (pop)  rptr_n = ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count_n = count + CW'(1);
        2'b01:   count_n = count - CW'(1);
        default: count_n = count;
      endcase
    end

    // Head register follows the next read pointer; a push into the head slot bypasses storage.
    if (count_n != '0) begin
      if (push && (rptr_n == wptr)) head_n = push_entry;
      else                          head_n = mem[rptr_n];
    end

    imem_req_n  = (state_n == FETCH) && (count_n < CW'(QDEPTH));
    ifq_valid_n = (count_n != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      fetch_pc  <= '0;
      req_pc    <= '0;
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      imem_req  <= 1'b0;
      ifq_valid <= 1'b0;
      head      <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      req_pc    <= req_pc_n;
      rptr      <= rptr_n;
      wptr      <= wptr_n;
      count     <= count_n;
      imem_req  <= imem_req_n;
      ifq_valid <= ifq_valid_n;
      head      <= head_n;
    end
  end

  // Queue storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_entry;
  end

`ifdef IFQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (ifq_ready && !ifq_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: straight-line fetch, backpressure, redirects, wrap and reset mid-request.
// Define IFQ_STALL_CNT_EN to also check the stall counter.
module tb_ifetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pop_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifq_valid;
  logic [31:0] ifq_instr;
  logic [31:0] ifq_pc;
  logic        ifq_ready;
`ifdef IFQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pop_t        pops[$];
  logic        pending;
  logic [31:0] paddr;
  int          pcnt;
  int          lat;

  ifetch_queue #(.QDEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ifq_valid   (ifq_valid),
    .ifq_instr   (ifq_instr),
    .ifq_pc      (ifq_pc),
    .ifq_ready   (ifq_ready)
`ifdef IFQ_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] idata(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: log events the DUT sees at the coming edge, then play the memory model after it.
  task automatic cyc();
    logic        got_grant;
    logic [31:0] gaddr;
    if (ifq_valid && ifq_ready && !redirect) pops.push_back('{pc: ifq_pc, instr: ifq_instr});
    got_grant = imem_req && imem_gnt;
    gaddr     = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (got_grant) begin
      pending = 1'b1;
      paddr   = gaddr;
      pcnt    = lat;
    end
    if (pending) begin
      if (pcnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = idata(paddr);
        pending     = 1'b0;
      end else begin
        pcnt--;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    pending     = 1'b0;
    run(2);
    pops.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_pop(input string tag, input int idx, input logic [31:0] exp_pc);
    if (idx < pops.size()) begin
      check({tag, "_pc"}, pops[idx].pc, exp_pc);
      check({tag, "_instr"}, pops[idx].instr, idata(exp_pc));
    end else begin
      check({tag, "_count"}, 32'(pops.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    ifq_ready   = 1'b0;
    pending     = 1'b0;
    paddr       = '0;
    pcnt        = 0;
    lat         = 1;
    #2;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_valid", 32'(ifq_valid), 32'd0);
    check("rst_addr",  imem_addr, 32'd0);
    check("rst_pc",    ifq_pc, 32'd0);
    check("rst_instr", ifq_instr, 32'd0);
`ifdef IFQ_STALL_CNT_EN
    check("rst_stall", stall_cnt, 32'd0);
`endif

    // Straight line
    imem_gnt  = 1'b1;
    ifq_ready = 1'b1;
    lat       = 1;
    do_reset();
    cyc();
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'd0);
    run(20);
    for (int i = 0; i < 4; i++) check_pop($sformatf("line%0d", i), i, 32'(i));
    for (int i = 1; i < pops.size(); i++)
      check($sformatf("line_order%0d", i), pops[i].pc, pops[i-1].pc + 32'd1);

    // Backpressure
    ifq_ready = 1'b0;
    do_reset();
    run(12);
    check("bp_req",   32'(imem_req), 32'd0);
    check("bp_valid", 32'(ifq_valid), 32'd1);
    check("bp_pc",    ifq_pc, 32'd0);
    check("bp_addr",  imem_addr, 32'd2);
    run(5);
    check("bp_pc_hold",    ifq_pc, 32'd0);
    check("bp_instr_hold", ifq_instr, idata(32'd0));
    ifq_ready = 1'b1;
    run(12);
    check_pop("bp0", 0, 32'd0);
    check_pop("bp1", 1, 32'd1);
    check_pop("bp2", 2, 32'd2);

    // Redirect while a request is outstanding
    lat = 3;
    do_reset();
    run(2);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    redirect = 1'b0;
    lat      = 1;
    check("rw_drain_req", 32'(imem_req), 32'd0);
    cyc();
    check("rw_drain_req2", 32'(imem_req), 32'd0);
    cyc();
    check("rw_req",   32'(imem_req), 32'd1);
    check("rw_addr",  imem_addr, 32'h40);
    check("rw_valid", 32'(ifq_valid), 32'd0);
    run(10);
    check_pop("rw0", 0, 32'h40);
    check_pop("rw1", 1, 32'h41);

    // Redirect together with rvalid and a pop
    ifq_ready = 1'b0;
    lat       = 2;
    do_reset();
    run(6);
    check("rv_pre_valid", 32'(ifq_valid), 32'd1);
    ifq_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    check("rv_valid", 32'(ifq_valid), 32'd0);
    check("rv_req",   32'(imem_req), 32'd1);
    check("rv_addr",  imem_addr, 32'h100);
    lat = 1;
    run(8);
    check_pop("rv0", 0, 32'h100);

    // Address wrap, redirect landing on a granted request
    lat = 1;
    do_reset();
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect = 1'b0;
    cyc();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFF);
    run(10);
    check_pop("wrap0", 0, 32'hFFFF_FFFF);
    check_pop("wrap1", 1, 32'h0000_0000);

    // Reset during WAIT, stale rvalid after release
    lat = 3;
    do_reset();
    run(2);
    rst_n = 1'b0;
    #1;
    check("rm_req",   32'(imem_req), 32'd0);
    check("rm_valid", 32'(ifq_valid), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rm_req2",  32'(imem_req), 32'd1);
    check("rm_addr",  imem_addr, 32'd0);
    cyc();
    check("rm_valid2", 32'(ifq_valid), 32'd0);
`ifdef IFQ_STALL_CNT_EN
    check("rm_stall", stall_cnt, 32'd2);
`endif
    cyc();
    check("rm_valid3", 32'(ifq_valid), 32'd0);
    run(10);
    check_pop("rm0", 0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
